// File: rtl/demux16_pkg.sv
// Shared constants for the 1:16 serial demultiplexer: lane count, select width,
// FSM state encoding and the even-parity helper used when DEMUX_PARITY_EN is defined.
// Contents: BITS, SEL_W, ST_IDLE/ST_SCAN/ST_PARITY, word_parity().
package demux16_pkg;

    // Lane count is fixed; the select/pointer width follows from it.
    localparam int BITS  = 16;
    localparam int SEL_W = $clog2(BITS);

    // FSM encoding. ST_PARITY is only reachable when DEMUX_PARITY_EN is defined.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    // Even parity of a full lane word: the correct parity bit makes ^{word,bit} == 0.
    function automatic logic word_parity(input logic [BITS-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/demux16_lane_dec.sv
// Lane write-enable decoder: one-hot enable for the lane addressed by sel (idle) or ptr (scan).
// Purely combinational, zero latency; no flow control of its own.
// Ports: wr_en (write strobe), idle (selects sel vs ptr), sel, ptr in; we[BITS] one-hot out.
module demux16_lane_dec
    import demux16_pkg::*;
(
    input  logic             wr_en,
    input  logic             idle,
    input  logic [SEL_W-1:0] sel,
    input  logic [SEL_W-1:0] ptr,
    output logic [BITS-1:0]  we
);

    logic [SEL_W-1:0] idx;

    // Manual mode addresses the lane with the external select, scan mode with the pointer.
    assign idx = idle ? sel : ptr;

    always_comb begin
        we = '0;
        if (wr_en) begin
            we = {{(BITS-1){1'b0}}, 1'b1} << idx;
        end
    end

endmodule

// File: rtl/demux1x16_deserializer.sv
// 1:16 serial demultiplexer: steers din onto 16 lanes, manually by sel or by an internal
// scan pointer that commits a whole frame to y at once. Latency 1 cycle for every write;
// din_valid may be held low indefinitely mid-frame (no timeout).
// Ports: wb_clk_i, wb_rst_i (async, active high), din/din_valid, sel, start in;
//        busy, ptr, shadow, y, frame_done, parity_err out.
// Optional feature macro: DEMUX_PARITY_EN adds a trailing even-parity bit per scan frame
// (PARITY state, sticky parity_err). Without it parity_err is tied low.
module demux1x16_deserializer
    import demux16_pkg::*;
(
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             din,
    input  logic             din_valid,
    input  logic [SEL_W-1:0] sel,
    input  logic             start,
    output logic             busy,
    output logic [SEL_W-1:0] ptr,
    output logic [BITS-1:0]  shadow,
    output logic [BITS-1:0]  y,
    output logic             frame_done,
    output logic             parity_err
);

    logic [1:0]      state;
    logic            is_idle;
    logic            is_scan;
    logic            bit_acc;
    logic            wr_en;
    logic            last_bit;
    logic [BITS-1:0] we;
    logic [BITS-1:0] din_rep;
    logic [BITS-1:0] shadow_nxt;
    logic [BITS-1:0] y_manual;

    assign is_idle = (state == ST_IDLE);
    assign is_scan = (state == ST_SCAN);
    assign busy    = !is_idle;

    // start always wins: a data bit arriving in the same cycle as start is dropped.
    assign bit_acc = din_valid && !start;

    // Only IDLE (manual) and SCAN write a lane; the parity bit is never stored.
    assign wr_en    = bit_acc && (is_idle || is_scan);
    assign last_bit = is_scan && bit_acc && (ptr == SEL_W'(BITS - 1));

    demux16_lane_dec u_lane_dec (
        .wr_en (wr_en),
        .idle  (is_idle),
        .sel   (sel),
        .ptr   (ptr),
        .we    (we)
    );

    assign din_rep    = {BITS{din}};
    assign shadow_nxt = (shadow & ~we) | (din_rep & we);
    assign y_manual   = (y & ~we) | (din_rep & we);

`ifdef DEMUX_PARITY_EN
    logic parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            shadow     <= '0;
            y          <= '0;
            frame_done <= 1'b0;
`ifdef DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            shadow     <= shadow_nxt;
            if (start) begin
                // Begin or restart a frame; shadow keeps its old contents and y is untouched.
                state <= ST_SCAN;
                ptr   <= '0;
`ifdef DEMUX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end else if (bit_acc) begin
                case (state)
                    ST_IDLE: begin
                        // Manual write goes straight through to the committed lane.
                        y <= y_manual;
                    end
                    ST_SCAN: begin
                        ptr <= ptr + SEL_W'(1);
                        if (last_bit) begin
`ifdef DEMUX_PARITY_EN
                            state <= ST_PARITY;
`else
                            y          <= shadow_nxt;
                            frame_done <= 1'b1;
                            state      <= ST_IDLE;
`endif
                        end
                    end
`ifdef DEMUX_PARITY_EN
                    ST_PARITY: begin
                        // Word commits even on a parity error; the error flag is sticky.
                        parity_err_q <= parity_err_q | (din != word_parity(shadow));
                        y            <= shadow;
                        frame_done   <= 1'b1;
                        state        <= ST_IDLE;
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux1x16_deserializer.sv
module tb_demux1x16_deserializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic [3:0]  sel;
    logic        start;
    logic        busy;
    logic [3:0]  ptr;
    logic [15:0] shadow;
    logic [15:0] y;
    logic        frame_done;
    logic        parity_err;

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;

    // Reference model: frame-level view (in_frame flag, count of bits collected so far)
    logic [15:0] m_y;
    logic [15:0] m_sh;
    bit          m_in_frame;
    int          m_cnt;
    bit          m_want_par;
    bit          m_perr;
    bit          m_fd;

    always #5 clk = ~clk;

    demux1x16_deserializer dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sel        (sel),
        .start      (start),
        .busy       (busy),
        .ptr        (ptr),
        .shadow     (shadow),
        .y          (y),
        .frame_done (frame_done),
        .parity_err (parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_y = '0; m_sh = '0; m_in_frame = 0; m_cnt = 0;
        m_want_par = 0; m_perr = 0; m_fd = 0;
    endtask

    task automatic model_cycle(input logic s, input logic v, input logic d, input logic [3:0] sl);
        m_fd = 0;
        if (s) begin
            m_in_frame = 1; m_cnt = 0; m_want_par = 0; m_perr = 0;
        end else if (v) begin
            if (!m_in_frame) begin
                m_sh[sl] = d;
                m_y[sl]  = d;
            end else if (m_want_par) begin
                if (d != ^m_sh) m_perr = 1;
                m_y = m_sh; m_fd = 1; m_in_frame = 0; m_want_par = 0; m_cnt = 0;
            end else begin
                m_sh[m_cnt] = d;
                m_cnt++;
                if (m_cnt == 16) begin
`ifdef DEMUX_PARITY_EN
                    m_want_par = 1;
`else
                    m_y = m_sh; m_fd = 1; m_in_frame = 0; m_cnt = 0;
`endif
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("y", 32'(y), 32'(m_y));
        chk("shadow", 32'(shadow), 32'(m_sh));
        chk("ptr", 32'(ptr), 32'(m_cnt % 16));
        chk("busy", 32'(busy), 32'(m_in_frame));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    task automatic step(input logic s, input logic v, input logic d, input logic [3:0] sl);
        start = s; din_valid = v; din = d; sel = sl;
        @(posedge clk);
        #1;
        model_cycle(s, v, d, sl);
        compare_all();
        if (frame_done === 1'b1) fd_cnt++;
        start = 1'b0; din_valid = 1'b0;
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 3);
        for (int g = 0; g < n; g++) step(1'b0, 1'b0, 1'($urandom), 4'($urandom));
    endtask

    task automatic send_bits(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            idle_gap();
            step(1'b0, 1'b1, w[i], 4'($urandom));
        end
    endtask

    initial begin
        int fd_before;
        logic [15:0] sh_before;
        rst = 1'b1; din = 0; din_valid = 0; sel = 0; start = 0;
        model_reset();
        #12;
        chk("reset_y", 32'(y), 32'h0);
        chk("reset_ptr", 32'(ptr), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Manual write of lane 5
        step(1'b0, 1'b1, 1'b1, 4'd5);
        chk("manual_y", 32'(y), 32'h0020);
        chk("manual_fd", 32'(frame_done), 32'h0);

        // Scan frame with random gaps
        fd_before = fd_cnt;
        step(1'b1, 1'b0, 1'b0, 4'd0);
        send_bits(16'hA5C3, 15);
        chk("scan_y_hold", 32'(y), 32'h0020);
        send_bits(16'hA5C3, 1);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("scan_fd_count", 32'(fd_cnt - fd_before), 32'(1));
        fd_before = fd_cnt;
        step(1'b1, 1'b0, 1'b0, 4'd0);
        send_bits(16'hA5C3, 15);
        fd_before = fd_cnt;
        idle_gap();
        step(1'b0, 1'b1, 1'b1, 4'd0);
        chk("scan_y", 32'(y), 32'hA5C3);
        chk("scan_fd_pulse", 32'(frame_done), 32'h1);
        chk("scan_busy_fall", 32'(busy), 32'h0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("scan_fd_1cyc", 32'(frame_done), 32'h0);

        // Restart mid-frame
        fd_before = fd_cnt;
        step(1'b1, 1'b0, 1'b0, 4'd0);
        send_bits(16'hFFFF, 7);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        send_bits(16'h1234, 16);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("restart_y", 32'(y), 32'h1234);
        chk("restart_fd_count", 32'(fd_cnt - fd_before), 32'(1));

        // Start and din_valid together
        sh_before = m_sh;
        step(1'b1, 1'b1, ~m_sh[0], 4'd0);
        chk("simul_shadow", 32'(shadow), 32'(sh_before));
        chk("simul_ptr", 32'(ptr), 32'h0);

        // Asynchronous reset after 9 scan bits
        send_bits(16'h5A5A, 9);
        #2 rst = 1'b1;
        #1;
        chk("arst_y", 32'(y), 32'h0);
        chk("arst_shadow", 32'(shadow), 32'h0);
        chk("arst_ptr", 32'(ptr), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 4'd0);

`ifdef DEMUX_PARITY_EN
        step(1'b1, 1'b0, 1'b0, 4'd0);
        send_bits(16'h0003, 16);
        step(1'b0, 1'b1, 1'b1, 4'd0);
        chk("par_err", 32'(parity_err), 32'h1);
        chk("par_y", 32'(y), 32'h0003);
        step(1'b0, 1'b1, 1'b0, 4'd3);
        chk("par_sticky", 32'(parity_err), 32'h1);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        chk("par_clear", 32'(parity_err), 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
